// File: rtl/muldiv_seq.sv
// Sequential RV32M multiply/divide unit: multi-cycle multiply with a fixed latency,
// 32-step restoring divide, and a valid/ready handshake on both request and response.
module muldiv_seq #(
    parameter int MUL_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  funct3,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] result,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    localparam logic [5:0] MUL_LAST = 6'(MUL_STAGES - 1);
    localparam logic [5:0] DIV_LAST = 6'd32;

    state_t      state_q, state_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [1:0]  op_q, op_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] dvs_q, dvs_d;
    logic [31:0] result_q, result_d;

    // Operand magnitudes taken straight from the request so the divider starts at once.
    logic        in_sgn;
    logic [31:0] in_abs_a, in_abs_b;
    assign in_sgn   = ~funct3[0];
    assign in_abs_a = (in_sgn && a[31]) ? (32'd0 - a) : a;
    assign in_abs_b = (in_sgn && b[31]) ? (32'd0 - b) : b;

    // Both operands sign/zero-extended to 64 bits; the low 64 product bits are then
    // correct for every signedness combination.
    logic        mul_sa, mul_sb;
    logic [63:0] mul_a, mul_b, prod;
    assign mul_sa = (op_q == 2'b01) || (op_q == 2'b10);
    assign mul_sb = (op_q == 2'b01);
    assign mul_a  = {{32{mul_sa & a_q[31]}}, a_q};
    assign mul_b  = {{32{mul_sb & b_q[31]}}, b_q};
    assign prod   = mul_a * mul_b;

    logic        div_sgn, a_neg, b_neg, div_zero, div_ovf;
    logic [32:0] rem_shift;
    logic        rem_ge;
    logic [31:0] rem_sub, quo_fix, rem_fix;
    assign div_sgn   = ~op_q[0];
    assign a_neg     = div_sgn & a_q[31];
    assign b_neg     = div_sgn & b_q[31];
    assign div_zero  = (b_q == 32'd0);
    assign div_ovf   = div_sgn && (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);
    assign rem_shift = {rem_q, quo_q[31]};
    assign rem_ge    = rem_shift >= {1'b0, dvs_q};
    assign rem_sub   = rem_shift[31:0] - dvs_q;
    assign quo_fix   = (a_neg ^ b_neg) ? (32'd0 - quo_q) : quo_q;
    assign rem_fix   = a_neg ? (32'd0 - rem_q) : rem_q;

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    a_d     = a;
                    b_d     = b;
                    op_d    = funct3[1:0];
                    cnt_d   = 6'd0;
                    rem_d   = 32'd0;
                    quo_d   = in_abs_a;
                    dvs_d   = in_abs_b;
                    state_d = funct3[2] ? DIV : MUL;
                end
            end
            MUL: begin
                if (cnt_q == MUL_LAST) begin
                    result_d = (op_q == 2'b00) ? prod[31:0] : prod[63:32];
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            DIV: begin
                if (cnt_q == 6'd0 && div_zero) begin
                    result_d = op_q[1] ? a_q : 32'hFFFF_FFFF;
                    state_d  = DONE;
                end else if (cnt_q == 6'd0 && div_ovf) begin
                    result_d = op_q[1] ? 32'd0 : 32'h8000_0000;
                    state_d  = DONE;
                end else if (cnt_q == DIV_LAST) begin
                    result_d = op_q[1] ? rem_fix : quo_fix;
                    state_d  = DONE;
                end else begin
                    rem_d = rem_ge ? rem_sub : rem_shift[31:0];
                    quo_d = {quo_q[30:0], rem_ge};
                    cnt_d = cnt_q + 6'd1;
                end
            end
            DONE: begin
                if (resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            result_q <= result_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == DONE);
    assign busy       = (state_q != IDLE);
    assign result     = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: hand-computed vectors, latency, stall, reset and
// back-to-back handshake behaviour.
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] a, b;
    logic [2:0]  funct3;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] result;
    logic        busy;

    int ncmp = 0;
    int nerr = 0;
    logic [31:0] last_res = 32'd0;

    muldiv_seq #(.MUL_STAGES(2)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .a(a), .b(b), .funct3(funct3), .resp_valid(resp_valid),
        .resp_ready(resp_ready), .result(result), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: got %08h want %08h", tag, obs, exp);
        end
    endtask

    // Present a request from IDLE; returns just after the accept edge E0 with
    // the inputs scrambled so any late sampling would show up.
    task automatic start(input string tag, input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        chk({tag, "_rdy"}, {31'd0, req_ready}, 32'd1);
        funct3 = f; a = x; b = y; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        a = 32'hDEAD_BEEF; b = 32'h0000_0003; funct3 = ~f;
        chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
        chk({tag, "_hold"}, result, last_res);
    endtask

    // Count edges from E0 until resp_valid, then check latency and value.
    task automatic wait_resp(input string tag, input int lat, input logic [31:0] exp);
        int n;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!resp_valid && n < 100);
        chk({tag, "_lat"}, 32'(n), 32'(lat));
        chk({tag, "_res"}, result, exp);
        last_res = exp;
    endtask

    task automatic handshake(input string tag);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chk({tag, "_rv0"}, {31'd0, resp_valid}, 32'd0);
    endtask

    task automatic op(input string tag, input logic [2:0] f, input logic [31:0] x,
                      input logic [31:0] y, input int lat, input logic [31:0] exp);
        start(tag, f, x, y);
        wait_resp(tag, lat, exp);
        handshake(tag);
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; resp_ready = 1'b0;
        a = '0; b = '0; funct3 = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_rv",    {31'd0, resp_valid}, 32'd0);
        chk("rst_busy",  {31'd0, busy}, 32'd0);
        chk("rst_res",   result, 32'd0);

        // multiply, MUL_STAGES=2
        op("mulh",   3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 32'h0000_0000);
        op("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 32'hFFFF_FFFE);
        op("mul",    3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 32'h0000_0001);
        op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 32'hFFFF_FFFF);
        op("mul2",   3'b000, 32'h0001_0000, 32'h0001_0003, 2, 32'h0003_0000);

        // iterative divide
        op("div",    3'b100, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFD);
        op("rem",    3'b110, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF);
        op("remu",   3'b111, 32'hFFFF_FFF9, 32'd2, 33, 32'h0000_0001);
        op("divu",   3'b101, 32'hFFFF_FFF9, 32'd2, 33, 32'h7FFF_FFFC);
        op("divneg", 3'b100, 32'd7, 32'hFFFF_FFFE, 33, 32'hFFFF_FFFD);
        op("remneg", 3'b110, 32'd7, 32'hFFFF_FFFE, 33, 32'h0000_0001);

        // fast-path divides
        op("divu0",  3'b101, 32'd5, 32'd0, 1, 32'hFFFF_FFFF);
        op("rem0",   3'b110, 32'd5, 32'd0, 1, 32'h0000_0005);
        op("divovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000);
        op("removf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h0000_0000);

        // stall in DONE with a competing request, then back-to-back accept
        start("stall", 3'b000, 32'd3, 32'd5);
        wait_resp("stall", 2, 32'd15);
        funct3 = 3'b000; a = 32'd9; b = 32'd9; req_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("stall_rv",  {31'd0, resp_valid}, 32'd1);
            chk("stall_res", result, 32'd15);
            chk("stall_rdy", {31'd0, req_ready}, 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chk("b2b_idle", {31'd0, req_ready}, 32'd1);
        chk("b2b_rv0",  {31'd0, resp_valid}, 32'd0);
        a = 32'd6; b = 32'd7;
        @(posedge clk); #1;
        req_valid = 1'b0;
        a = 32'hDEAD_BEEF;
        chk("b2b_busy", {31'd0, busy}, 32'd1);
        wait_resp("b2b", 2, 32'd42);
        handshake("b2b");

        // reset in the middle of an iterative divide
        start("rstdiv", 3'b100, 32'd100, 32'd7);
        repeat (15) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        last_res = 32'd0;
        chk("rstdiv_rv",   {31'd0, resp_valid}, 32'd0);
        chk("rstdiv_res",  result, 32'd0);
        chk("rstdiv_rdy",  {31'd0, req_ready}, 32'd1);
        chk("rstdiv_busy", {31'd0, busy}, 32'd0);
        repeat (40) @(posedge clk);
        #1 chk("rstdiv_quiet", {31'd0, resp_valid}, 32'd0);
        op("div2", 3'b100, 32'd100, 32'd7, 33, 32'd14);
        op("rem2", 3'b110, 32'd100, 32'd7, 33, 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
